mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory-access stage fed by the execute/memory control pipeline register (consumes reg_wrMW, Mem_read,
//  Mem_write, WB_sel_MW). Runs load/store transactions on a req/ack data-memory port and aligns and
//  sign-extends load data. Holds the pipeline via Stall until the access completes, then drives writeback.
// PARAMETERS
//  XLEN            32   data/address width
//  TIMEOUT_CYCLES  255  max BUSY cycles waiting for dmem_ack before bus error (>=1, fits 8-bit counter)
// PORTS
//  clk          in   1     single clock, all state on posedge
//  rst          in   1     synchronous, active-high reset
//  Mem_read     in   1     load in MW stage      | Mem_write  in 1   store in MW stage
//  reg_wrMW     in   1     rd write request      | WB_sel_MW  in 2   00 ALU, 01 load, 10 PC+4, 11 -> 0
//  funct3_MW    in   3     000 B, 001 H, 010 W, 100 BU, 101 HU (others: treated as W)
//  alu_out_MW   in   XLEN  ALU result / effective address  | wdata_MW in XLEN store data (rs2)
//  pc_MW        in   XLEN  instruction PC
//  dmem_req     out  1     request, held until ack | dmem_we out 1 write strobe
//  dmem_addr    out  XLEN  word-aligned address (alu_out_MW & ~3) | dmem_be out 4 byte enables
//  dmem_wdata   out  XLEN  lane-replicated store data
//  dmem_ack     in   1     completion; dmem_rdata in XLEN valid when ack=1 for a load
//  Stall        out  1     hold upstream pipeline registers
//  wb_en        out  1     rd write enable | wb_data out XLEN writeback value
//  bus_err      out  1     one-cycle pulse on timeout
//  misalign_exc out  1     one-cycle pulse (present only with MEM_MISALIGN_TRAP_EN)
// BEHAVIOUR
//  Reset values: state=IDLE, counter=0, load buffer=0; dmem_req/we/be=0, Stall=0, wb_en=0, bus_err=0, exc=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE. acc = Mem_read|Mem_write. Both high: store ignored, treated as load.
//  IDLE: acc=0 -> Stall=0, passthrough wb. acc=1 -> Stall=1 (combinational), next state BUSY.
//  BUSY: dmem_req=1, addr/be/we/wdata from current MW inputs (stable, pipeline held); Stall=1;
//    counter increments each cycle; ack (may be first BUSY cycle) -> capture aligned load data, go DONE;
//    counter==TIMEOUT_CYCLES-1 without ack -> drop req, go DONE, buffer=0, bus_err pulses in DONE.
//  DONE: Stall=0, dmem_req=0, pipeline advances on this edge; never re-issues though Mem_read is still
//    high; next state IDLE. Minimum cost: 2 stall cycles per access; wb happens in DONE.
//  wb_data: WB_sel 00 alu_out_MW, 01 load buffer, 10 pc_MW+4 (mod 2^XLEN), 11 zero.
//  wb_en = reg_wrMW & ~Stall & ~bus_err & ~misalign_exc.
//  Store lanes: B be=1<<a[1:0], data {4{b}}; H be=a[1]?1100:0011, data {2{h}}; W be=1111.
//  Load: select byte/half by a[1:0]; 000/001 sign-extend, 100/101 zero-extend.
//  ack in IDLE/DONE (late/spurious): ignored. rst in any state: IDLE next cycle, req drops, counter cleared.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: H with a[0]=1 or W with a[1:0]!=0 -> no request; IDLE->DONE directly
//    (1 stall cycle), misalign_exc pulses in DONE, no wb, no memory side effect.
//  Undefined: no misalign_exc port; misaligned offsets are forced aligned (H clears a[0], W clears a[1:0]).
// STRUCTURE
//  Package masf_lsu_pkg: state enum {IDLE,BUSY,DONE}, funct3 size constants, WB_SEL_* constants.
//  Sub-module lsu_load_align (combinational): rdata + a[1:0] + funct3 -> extended XLEN load value.
// TESTING
//  LW a=0x100, ack 1st BUSY cycle, rdata=0xDEADBEEF -> Stall 2 cycles, DONE wb_data=0xDEADBEEF, wb_en=1.
//  LB a=0x103 rdata=0x80xxxxxx -> 0xFFFFFF80; LBU same -> 0x00000080; LH a=0x102 0x8001xxxx -> 0xFFFF8001.
//  SB a=0x101 wdata=0x12345678 -> be=0010, wdata=0x78787878, we=1, wb_en=0 with reg_wrMW=0.
//  No ack, TIMEOUT_CYCLES=4 -> req 4 cycles, then bus_err pulse in DONE, wb_en=0, back to IDLE.
//  rst asserted in BUSY cycle 2, ack arrives next cycle -> req=0, IDLE, ack ignored, no wb.
//  MEM_MISALIGN_TRAP_EN, LW a=0x101 -> no dmem_req, 1 stall, misalign_exc=1; without: addr 0x100 read.

Source files
------------

// File: rtl/masf_lsu_pkg.sv
// -----------------------------------------------------------------------------
// masf_lsu_pkg
// Shared types and constants for the memory-access stage:
//   lsu_state_e  - access FSM states (IDLE, BUSY, DONE)
//   F3_*         - funct3 access-size encodings
//   WB_SEL_*     - writeback source select encodings
//   acc_size_e   - decoded access width, plus f3_size() to decode funct3
// -----------------------------------------------------------------------------
package masf_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_ZERO = 2'b11;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  // Unlisted funct3 encodings fall back to a full-word access.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data aligner: picks the addressed byte/halfword out of
// the memory word and sign- or zero-extends it to XLEN.
// Ports:
//   rdata_i   in  XLEN  raw word from data memory
//   off_i     in  2     byte offset within the word (already size-aligned)
//   funct3_i  in  3     access size/sign (B, H, W, BU, HU; others act as W)
//   data_o    out XLEN  extended load value
// -----------------------------------------------------------------------------
module lsu_load_align
  import masf_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access pipeline stage. Turns a load/store sitting in the MW register
// into a req/ack transaction on the data-memory port, holds the pipeline with
// Stall until it completes (or times out), aligns/extends load data and drives
// the writeback port.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned H/W accesses are not issued; misalign_exc pulses
//   undefined - misaligned H/W offsets are silently forced aligned
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Mem_read, Mem_write      access request from MW (both high -> load)
//   reg_wrMW, WB_sel_MW      rd write request and writeback source
//   funct3_MW                access size / sign
//   alu_out_MW               effective address / ALU result
//   wdata_MW, pc_MW          store data, instruction PC
//   dmem_req/we/addr/be/wdata  data-memory request side
//   dmem_ack, dmem_rdata     data-memory response side
//   Stall                    hold upstream pipeline registers
//   wb_en, wb_data           register-file writeback
//   bus_err                  one-cycle pulse after an ack timeout
//   misalign_exc             one-cycle pulse (MEM_MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module mem_access_stage
  import masf_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Mem_read,
  input  logic            Mem_write,
  input  logic            reg_wrMW,
  input  logic [1:0]      WB_sel_MW,
  input  logic [2:0]      funct3_MW,
  input  logic [XLEN-1:0] alu_out_MW,
  input  logic [XLEN-1:0] wdata_MW,
  input  logic [XLEN-1:0] pc_MW,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            Stall,
  output logic            wb_en,
  output logic [XLEN-1:0] wb_data,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            misalign_exc,
`endif
  output logic            bus_err
);

  // Counter value at which the last BUSY cycle without an ack gives up.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            berr_q, berr_d;
  logic            mis_q, mis_d;

  logic            acc, is_load, is_store;
  acc_size_e       size;
  logic [1:0]      raw_off, off;
  logic [3:0]      be_lane;
  logic [XLEN-1:0] st_data;
  logic [XLEN-1:0] ld_aligned;

  // A simultaneous read+write is handled purely as a load.
  assign acc      = Mem_read | Mem_write;
  assign is_load  = Mem_read;
  assign is_store = Mem_write & ~Mem_read;

  assign size    = f3_size(funct3_MW);
  assign raw_off = alu_out_MW[1:0];

  // Offsets are forced to the access size; in the trap build misaligned
  // accesses never reach BUSY, so this only matters without the trap.
  always_comb begin
    case (size)
      SZ_B:    off = raw_off;
      SZ_H:    off = {raw_off[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  always_comb begin
    case (size)
      SZ_B: begin
        be_lane = 4'b0001 << off;
        st_data = {(XLEN/8){wdata_MW[7:0]}};
      end
      SZ_H: begin
        be_lane = off[1] ? 4'b1100 : 4'b0011;
        st_data = {(XLEN/16){wdata_MW[15:0]}};
      end
      default: begin
        be_lane = 4'b1111;
        st_data = wdata_MW;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size == SZ_H) && raw_off[0]) ||
                      ((size == SZ_W) && (raw_off != 2'b00));
`endif

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i  (dmem_rdata),
    .off_i    (off),
    .funct3_i (funct3_MW),
    .data_o   (ld_aligned)
  );

  assign dmem_addr  = {alu_out_MW[XLEN-1:2], 2'b00};
  assign dmem_wdata = st_data;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    berr_d   = 1'b0;
    mis_d    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    dmem_be  = 4'b0000;
    Stall    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (acc) begin
          Stall = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        dmem_be  = be_lane;
        Stall    = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        if (dmem_ack) begin
          if (is_load) buf_d = ld_aligned;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          buf_d   = '0;
          berr_d  = 1'b1;
          state_d = DONE;
        end
      end
      // The MW register advances on this edge, so the still-asserted
      // Mem_read/Mem_write of the finished access must not re-issue.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      buf_q   <= '0;
      berr_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      berr_q  <= berr_d;
      mis_q   <= mis_d;
    end
  end

  assign bus_err = berr_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_exc = mis_q;
  assign wb_en = reg_wrMW & ~Stall & ~berr_q & ~mis_q;
`else
  assign wb_en = reg_wrMW & ~Stall & ~berr_q;
`endif

  always_comb begin
    case (WB_sel_MW)
      WB_SEL_ALU:  wb_data = alu_out_MW;
      WB_SEL_LOAD: wb_data = buf_q;
      WB_SEL_PC4:  wb_data = pc_MW + XLEN'(4);
      default:     wb_data = '0;
    endcase
  end

  // mis_q only feeds outputs in the trap build.
  logic unused_ok;
  assign unused_ok = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_read, Mem_write, reg_wrMW;
  logic [1:0]  WB_sel_MW;
  logic [2:0]  funct3_MW;
  logic [31:0] alu_out_MW, wdata_MW, pc_MW;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        Stall, wb_en, bus_err;
  logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .Mem_read(Mem_read), .Mem_write(Mem_write),
    .reg_wrMW(reg_wrMW), .WB_sel_MW(WB_sel_MW), .funct3_MW(funct3_MW),
    .alu_out_MW(alu_out_MW), .wdata_MW(wdata_MW), .pc_MW(pc_MW),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .Stall(Stall), .wb_en(wb_en), .wb_data(wb_data),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_exc(misalign_exc),
`endif
    .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] tb_buf = 32'h0;  // model of the load buffer

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned offs;
    logic [31:0] sh;
    case (f3)
      3'b000, 3'b100: offs = a % 4;
      3'b001, 3'b101: offs = (a % 4) & 2;
      default:        offs = 0;
    endcase
    sh = rd >> (8 * offs);
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b100:  return sh & 32'hFF;
      3'b001:  return 32'($signed(sh[15:0]));
      3'b101:  return sh & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000, 3'b100: return 4'(1 << (a % 4));
      3'b001, 3'b101: return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      default:        return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000, 3'b100: return (wd & 32'hFF) * 32'h01010101;
      3'b001, 3'b101: return (wd & 32'hFFFF) * 32'h00010001;
      default:        return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_wb(input logic [1:0] sel, input logic [31:0] alu,
                                       input logic [31:0] pc, input logic [31:0] ld);
    case (sel)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  // One complete access, starting from IDLE at posedge+1. delay = index of
  // the BUSY cycle carrying ack; delay >= TMO means the memory never answers.
  task automatic run_access(input string nm, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] pc,
                            input logic [1:0] sel, input logic rw,
                            input logic [31:0] rdata, input int delay,
                            input logic [31:0] exp_wb, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
    logic acked = 1'b0;
    Mem_read = rd; Mem_write = wr; funct3_MW = f3; alu_out_MW = a;
    wdata_MW = wd; pc_MW = pc; WB_sel_MW = sel; reg_wrMW = rw; dmem_ack = 1'b0;
    #4;
    chk({nm, " idle_stall"}, 32'(Stall), 32'd1);
    chk({nm, " idle_req"}, 32'(dmem_req), 32'd0);
    tick();
    for (int k = 0; k < TMO; k++) begin
      dmem_ack = (k == delay);
      dmem_rdata = (k == delay) ? rdata : $urandom;
      #4;
      chk({nm, " busy_req"}, 32'(dmem_req), 32'd1);
      chk({nm, " busy_stall"}, 32'(Stall), 32'd1);
      chk({nm, " addr"}, dmem_addr, a & ~32'h3);
      chk({nm, " we"}, 32'(dmem_we), 32'(wr & ~rd));
      if (wr && !rd) begin
        chk({nm, " be"}, 32'(dmem_be), 32'(exp_be));
        chk({nm, " wdata"}, dmem_wdata, exp_wd);
      end
      tick();
      dmem_ack = 1'b0;
      if (k == delay) begin
        acked = 1'b1;
        break;
      end
    end
    // DONE: a spurious ack here must not start anything.
    dmem_ack = 1'b1;
    #4;
    chk({nm, " done_stall"}, 32'(Stall), 32'd0);
    chk({nm, " done_req"}, 32'(dmem_req), 32'd0);
    chk({nm, " bus_err"}, 32'(bus_err), 32'(!acked));
    chk({nm, " wb_en"}, 32'(wb_en), 32'(rw & acked));
    chk({nm, " wb_data"}, wb_data, exp_wb);
    tick();
    dmem_ack = 1'b0; Mem_read = 1'b0; Mem_write = 1'b0;
    #4;
    chk({nm, " after_req"}, 32'(dmem_req), 32'd0);
    chk({nm, " after_err"}, 32'(bus_err), 32'd0);
    tick();
    if (!acked) tb_buf = 32'h0;
    else if (rd) tb_buf = m_load(f3, a, rdata);
  endtask

  typedef struct {
    string       nm;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdata;
    logic [1:0]  sel;
    logic        rw;
    int          delay;
    logic [31:0] exp_wb;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"LW",  1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2'd1, 1, 0, 32'hDEADBEEF, 4'h0, 32'h0};
    vecs[1] = '{"LB",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 2'd1, 1, 1, 32'hFFFFFF80, 4'h0, 32'h0};
    vecs[2] = '{"LBU", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 2'd1, 1, 2, 32'h00000080, 4'h0, 32'h0};
    vecs[3] = '{"LH",  1, 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 2'd1, 1, 0, 32'hFFFF8001, 4'h0, 32'h0};
    vecs[4] = '{"LHU", 1, 0, 3'b101, 32'h100, 32'h0, 32'h1234ABCD, 2'd1, 1, 1, 32'h0000ABCD, 4'h0, 32'h0};
    vecs[5] = '{"SB",  0, 1, 3'b000, 32'h101, 32'h12345678, 32'h0, 2'd0, 0, 0, 32'h00000101, 4'b0010, 32'h78787878};
    vecs[6] = '{"SH",  0, 1, 3'b001, 32'h102, 32'hCAFEBABE, 32'h0, 2'd0, 0, 2, 32'h00000102, 4'b1100, 32'hBABEBABE};
    vecs[7] = '{"SW",  0, 1, 3'b010, 32'h104, 32'h0BADF00D, 32'h0, 2'd2, 1, 1, 32'h00001004, 4'b1111, 32'h0BADF00D};
    vecs[8] = '{"LWZ", 1, 0, 3'b010, 32'h108, 32'h0, 32'h11111111, 2'd3, 1, 0, 32'h00000000, 4'h0, 32'h0};
    vecs[9] = '{"LBP", 1, 0, 3'b000, 32'h100, 32'h0, 32'h0000007F, 2'd1, 1, 0, 32'h0000007F, 4'h0, 32'h0};

    rst = 1'b1; Mem_read = 0; Mem_write = 0; reg_wrMW = 0; WB_sel_MW = 2'd1;
    funct3_MW = 3'b010; alu_out_MW = 32'h0; wdata_MW = 32'h0; pc_MW = 32'h0;
    dmem_ack = 0; dmem_rdata = 32'h0;
    tick();
    #4;
    chk("rst req", 32'(dmem_req), 32'd0);
    chk("rst stall", 32'(Stall), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst wb_en", 32'(wb_en), 32'd0);
    chk("rst load_buf", wb_data, 32'd0);
    tick();
    rst = 1'b0;

    // Passthrough while idle, including PC+4 wraparound and a stray ack.
    reg_wrMW = 1; WB_sel_MW = 2'd0; alu_out_MW = 32'h13572468; dmem_ack = 1;
    #4;
    chk("pass wb_en", 32'(wb_en), 32'd1);
    chk("pass alu", wb_data, 32'h13572468);
    chk("pass stall", 32'(Stall), 32'd0);
    tick();
    WB_sel_MW = 2'd2; pc_MW = 32'hFFFFFFFC;
    #4;
    chk("pass pc4_wrap", wb_data, 32'h0);
    chk("stray_ack req", 32'(dmem_req), 32'd0);
    tick();
    dmem_ack = 0;

    for (int i = 0; i < 10; i++)
      run_access(vecs[i].nm, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd,
                 32'h1000, vecs[i].sel, vecs[i].rw, vecs[i].rdata, vecs[i].delay,
                 vecs[i].exp_wb, vecs[i].exp_be, vecs[i].exp_wd);

    // Timeout: no ack ever; buffer cleared, bus_err pulse, no writeback.
    run_access("TMO", 1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 2'd1, 1, 32'h0, 99,
               32'h0, 4'h0, 32'h0);

    // Reset in the second BUSY cycle, ack arrives the cycle after.
    Mem_read = 1; funct3_MW = 3'b010; alu_out_MW = 32'h300; reg_wrMW = 1; WB_sel_MW = 2'd1;
    #4; chk("rstb idle_stall", 32'(Stall), 32'd1);
    tick();
    #4; chk("rstb busy1_req", 32'(dmem_req), 32'd1);
    tick();
    rst = 1;
    #4; chk("rstb busy2_req", 32'(dmem_req), 32'd1);
    tick();
    rst = 0; dmem_ack = 1; dmem_rdata = 32'h55555555;
    #4;
    chk("rstb req_dropped", 32'(dmem_req), 32'd0);
    chk("rstb wb_en", 32'(wb_en), 32'd0);
    chk("rstb stall", 32'(Stall), 32'd1);
    tick();
    dmem_ack = 0;
    // Re-issued access must get a full, freshly counted timeout window.
    for (int k = 0; k < TMO; k++) begin
      #4; chk("rstb reissue_req", 32'(dmem_req), 32'd1);
      tick();
    end
    #4;
    chk("rstb bus_err", 32'(bus_err), 32'd1);
    chk("rstb wb_en_done", 32'(wb_en), 32'd0);
    chk("rstb buf_zero", wb_data, 32'd0);
    tick();
    Mem_read = 0;
    #4; chk("rstb idle_req", 32'(dmem_req), 32'd0);
    tick();
    tb_buf = 32'h0;

`ifdef MEM_MISALIGN_TRAP_EN
    Mem_read = 1; funct3_MW = 3'b010; alu_out_MW = 32'h101; reg_wrMW = 1; WB_sel_MW = 2'd1;
    #4;
    chk("mis idle_stall", 32'(Stall), 32'd1);
    chk("mis idle_req", 32'(dmem_req), 32'd0);
    tick();
    #4;
    chk("mis done_req", 32'(dmem_req), 32'd0);
    chk("mis done_stall", 32'(Stall), 32'd0);
    chk("mis exc", 32'(misalign_exc), 32'd1);
    chk("mis wb_en", 32'(wb_en), 32'd0);
    tick();
    Mem_read = 0;
    #4;
    chk("mis exc_clear", 32'(misalign_exc), 32'd0);
    chk("mis after_req", 32'(dmem_req), 32'd0);
    tick();
`else
    run_access("MISW", 1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 2'd1, 1, 32'hA5A5A5A5, 0,
               32'hA5A5A5A5, 4'h0, 32'h0);
    run_access("MISH", 1, 0, 3'b001, 32'h103, 32'h0, 32'h0, 2'd1, 1, 32'h80011234, 0,
               32'hFFFF8001, 4'h0, 32'h0);
`endif

    // Randomized accesses against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3s[7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
      logic [2:0]  f3;
      logic [31:0] a, wd, pc, rdata, ld, exp_wb;
      logic        rd, wr, rw;
      logic [1:0]  sel;
      int          kind, delay;
      f3 = f3s[$urandom_range(0, 6)];
      a = $urandom; wd = $urandom; pc = $urandom; rdata = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      if (f3 == 3'b001 || f3 == 3'b101) a = a & ~32'h1;
      else if (f3 != 3'b000 && f3 != 3'b100) a = a & ~32'h3;
`endif
      kind = $urandom_range(0, 2);
      rd = (kind != 1); wr = (kind != 0);
      sel = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      delay = $urandom_range(0, 5);
      if (delay >= TMO) ld = 32'h0;
      else if (rd) ld = m_load(f3, a, rdata);
      else ld = tb_buf;
      exp_wb = m_wb(sel, a, pc, ld);
      run_access("RND", rd, wr, f3, a, wd, pc, sel, rw, rdata, delay,
                 exp_wb, m_be(f3, a), m_wdata(f3, wd));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
